ex_mem_stage: RTL and testbench

EX/MEM pipeline stage for the pipelined MIPS datapath. It latches execute-stage results and drives the data-cache request handshake, holding the request until `dhit`. It also publishes the destination register, write enable and ALU result that the forwarding unit compares against, and stalls the pipeline while a data access is outstanding.

---
 rtl/ex_mem_stage.sv | 116 +++++++++++
 tb/tb_ex_mem_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-cache request handshake.
// State | meaning
//   IDLE | no outstanding access, latched entry needs no memory
//   REQ  | request driven from latched dren/dwen, waiting for dhit
//   DONE | access completed, requests dropped, waiting for en
module ex_mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_rw,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_dren,
  input  logic              ex_dwen,
  input  logic              ex_halt,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [REG_W-1:0]  mem_rw,
  output logic              mem_regwrite,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_load_pending,
  output logic [WORD_W-1:0] mem_wb_data,
  output logic              mem_stall,
  output logic              mem_halt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              l_valid, l_regwrite, l_memtoreg, l_dren, l_dwen, l_halt;
  logic [REG_W-1:0]  l_rw;
  logic [WORD_W-1:0] l_alu, l_store, load_data;

  logic n_valid, n_regwrite, n_memtoreg, n_dren, n_dwen, n_halt;
  logic advance, in_req, rd_access, capture;

  // A store takes priority when both dren and dwen are latched.
  assign in_req    = (state == REQ);
  assign rd_access = l_dren & ~l_dwen;
  assign capture   = in_req & dhit & rd_access;

  assign mem_stall = in_req & ~dhit;
  assign advance   = en & ~mem_stall & ~mem_halt;

  assign n_valid    = ~flush & ex_valid;
  assign n_regwrite = ~flush & ex_regwrite;
  assign n_memtoreg = ~flush & ex_memtoreg;
  assign n_dren     = ~flush & ex_dren;
  assign n_dwen     = ~flush & ex_dwen;
  assign n_halt     = ~flush & ex_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      l_valid    <= 1'b0;
      l_rw       <= '0;
      l_regwrite <= 1'b0;
      l_memtoreg <= 1'b0;
      l_dren     <= 1'b0;
      l_dwen     <= 1'b0;
      l_halt     <= 1'b0;
      l_alu      <= '0;
      l_store    <= '0;
      load_data  <= '0;
      mem_halt   <= 1'b0;
    end else begin
      if (capture)
        load_data <= dmemload;
      if (advance) begin
        l_valid    <= n_valid;
        l_rw       <= flush ? '0 : ex_rw;
        l_regwrite <= n_regwrite;
        l_memtoreg <= n_memtoreg;
        l_dren     <= n_dren;
        l_dwen     <= n_dwen;
        l_halt     <= n_halt;
        l_alu      <= flush ? '0 : ex_alu_out;
        l_store    <= flush ? '0 : ex_store;
        state      <= (n_valid & (n_dren | n_dwen)) ? REQ : IDLE;
        if (n_valid & n_halt)
          mem_halt <= 1'b1;
      end else if (in_req && dhit) begin
        state <= DONE;
      end
    end
  end

  assign dmemREN   = in_req & rd_access;
  assign dmemWEN   = in_req & l_dwen;
  assign dmemaddr  = l_alu;
  assign dmemstore = l_store;

  assign mem_rw           = l_rw;
  assign mem_regwrite     = l_regwrite & l_valid;
  assign mem_data         = l_alu;
  assign mem_load_pending = in_req & rd_access & l_valid;

  // On the dhit cycle the load data bypasses the capture register so MEM/WB
  // can take it on the same edge the next instruction is latched.
  assign mem_wb_data = !l_memtoreg ? l_alu :
                       capture     ? dmemload : load_data;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage; inputs change and outputs are
// sampled on the falling edge.
module tb_ex_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, ex_valid, ex_regwrite, ex_memtoreg, ex_dren, ex_dwen, ex_halt;
  logic [4:0]  ex_rw;
  logic [31:0] ex_alu_out, ex_store, dmemload;
  logic        dhit;
  logic        dmemREN, dmemWEN, mem_regwrite, mem_load_pending, mem_stall, mem_halt;
  logic [31:0] dmemaddr, dmemstore, mem_data, mem_wb_data;
  logic [4:0]  mem_rw;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ex_mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_halt(ex_halt), .ex_alu_out(ex_alu_out), .ex_store(ex_store),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
    .mem_data(mem_data), .mem_load_pending(mem_load_pending),
    .mem_wb_data(mem_wb_data), .mem_stall(mem_stall), .mem_halt(mem_halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rw, input logic rwe,
                        input logic m2r, input logic dr, input logic dw,
                        input logic h, input logic [31:0] alu, input logic [31:0] st);
    ex_valid = v; ex_rw = rw; ex_regwrite = rwe; ex_memtoreg = m2r;
    ex_dren = dr; ex_dwen = dw; ex_halt = h; ex_alu_out = alu; ex_store = st;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ren"},   {31'd0, dmemREN}, 32'd0);
    check({tag, ".wen"},   {31'd0, dmemWEN}, 32'd0);
    check({tag, ".addr"},  dmemaddr, 32'd0);
    check({tag, ".store"}, dmemstore, 32'd0);
    check({tag, ".rw"},    {27'd0, mem_rw}, 32'd0);
    check({tag, ".rwe"},   {31'd0, mem_regwrite}, 32'd0);
    check({tag, ".data"},  mem_data, 32'd0);
    check({tag, ".lpend"}, {31'd0, mem_load_pending}, 32'd0);
    check({tag, ".wb"},    mem_wb_data, 32'd0);
    check({tag, ".stall"}, {31'd0, mem_stall}, 32'd0);
    check({tag, ".halt"},  {31'd0, mem_halt}, 32'd0);
  endtask

  initial begin
    nRST = 1'b0; en = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = 32'd0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check_all_zero("reset");
    nRST = 1'b1;

    // ALU op
    set_ex(1, 5, 1, 0, 0, 0, 0, 32'h10, 0);
    en = 1'b1;
    tick();
    check("alu.rw",    {27'd0, mem_rw}, 32'd5);
    check("alu.rwe",   {31'd0, mem_regwrite}, 32'd1);
    check("alu.data",  mem_data, 32'h10);
    check("alu.wb",    mem_wb_data, 32'h10);
    check("alu.ren",   {31'd0, dmemREN}, 32'd0);
    check("alu.wen",   {31'd0, dmemWEN}, 32'd0);
    check("alu.stall", {31'd0, mem_stall}, 32'd0);

    // Load at 0x40, dhit on third request cycle, en held high
    set_ex(1, 8, 1, 1, 1, 0, 0, 32'h40, 0);
    tick();
    set_ex(1, 9, 1, 0, 0, 0, 0, 32'h99, 0);
    check("ld.c1.ren",   {31'd0, dmemREN}, 32'd1);
    check("ld.c1.stall", {31'd0, mem_stall}, 32'd1);
    check("ld.c1.lpend", {31'd0, mem_load_pending}, 32'd1);
    check("ld.c1.addr",  dmemaddr, 32'h40);
    tick();
    check("ld.c2.ren",   {31'd0, dmemREN}, 32'd1);
    check("ld.c2.stall", {31'd0, mem_stall}, 32'd1);
    check("ld.c2.rw",    {27'd0, mem_rw}, 32'd8);
    tick();
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    check("ld.c3.ren",   {31'd0, dmemREN}, 32'd1);
    check("ld.c3.stall", {31'd0, mem_stall}, 32'd0);
    check("ld.c3.wb",    mem_wb_data, 32'hDEADBEEF);
    tick();
    dhit = 1'b0; dmemload = 32'd0;
    check("ld.next.rw",    {27'd0, mem_rw}, 32'd9);
    check("ld.next.data",  mem_data, 32'h99);
    check("ld.next.ren",   {31'd0, dmemREN}, 32'd0);
    check("ld.next.stall", {31'd0, mem_stall}, 32'd0);

    // Store 0xCAFE to 0x80, completed while en is low
    set_ex(1, 0, 0, 0, 0, 1, 0, 32'h80, 32'hCAFE);
    tick();
    en = 1'b0;
    set_ex(1, 10, 1, 0, 0, 0, 0, 32'hA0, 0);
    check("st.wen",   {31'd0, dmemWEN}, 32'd1);
    check("st.ren",   {31'd0, dmemREN}, 32'd0);
    check("st.addr",  dmemaddr, 32'h80);
    check("st.data",  dmemstore, 32'hCAFE);
    check("st.stall", {31'd0, mem_stall}, 32'd1);
    dhit = 1'b1;
    #1;
    check("st.hit.stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dhit = 1'b0;
    check("st.done.wen",   {31'd0, dmemWEN}, 32'd0);
    check("st.done.stall", {31'd0, mem_stall}, 32'd0);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    check("st.done2.wen",  {31'd0, dmemWEN}, 32'd0);
    check("st.done2.addr", mem_data, 32'h80);
    en = 1'b1;
    tick();
    check("st.adv.rw",   {27'd0, mem_rw}, 32'd10);
    check("st.adv.data", mem_data, 32'hA0);
    check("st.adv.wen",  {31'd0, dmemWEN}, 32'd0);

    // Flush with and without en
    set_ex(1, 7, 1, 0, 1, 0, 0, 32'h77, 0);
    flush = 1'b1;
    tick();
    check("fl.rwe", {31'd0, mem_regwrite}, 32'd0);
    check("fl.ren", {31'd0, dmemREN}, 32'd0);
    check("fl.wen", {31'd0, dmemWEN}, 32'd0);
    check("fl.rw",  {27'd0, mem_rw}, 32'd0);
    flush = 1'b0;
    set_ex(1, 11, 1, 0, 0, 0, 0, 32'hB0, 0);
    tick();
    check("fl.load.rw", {27'd0, mem_rw}, 32'd11);
    en = 1'b0; flush = 1'b1;
    set_ex(1, 7, 1, 0, 0, 0, 0, 32'h77, 0);
    tick();
    check("fl.hold.rw",  {27'd0, mem_rw}, 32'd11);
    check("fl.hold.rwe", {31'd0, mem_regwrite}, 32'd1);
    check("fl.hold.data", mem_data, 32'hB0);
    flush = 1'b0;

    // Halt freezes everything
    set_ex(1, 12, 0, 0, 0, 0, 1, 32'hC0, 0);
    en = 1'b1;
    tick();
    check("halt.set", {31'd0, mem_halt}, 32'd1);
    check("halt.rw",  {27'd0, mem_rw}, 32'd12);
    set_ex(1, 13, 1, 0, 0, 0, 0, 32'hD0, 0);
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check("halt.stay", {31'd0, mem_halt}, 32'd1);
    check("halt.rw2",  {27'd0, mem_rw}, 32'd12);
    check("halt.data", mem_data, 32'hC0);

    // Reset mid-REQ
    en = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    set_ex(1, 14, 1, 1, 1, 0, 0, 32'h40, 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst.pre.ren", {31'd0, dmemREN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rst.async.ren",   {31'd0, dmemREN}, 32'd0);
    check("rst.async.stall", {31'd0, mem_stall}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    check_all_zero("rst.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
